l2_tag_stage_nway: RTL and testbench

Parametrised L2 tag-check stage. It replaces the fixed 4-way tag stage with configurable ways, sets and tag width. It adds:
- a post-reset init sweep
- downstream stall with array-snoop of the held request
- same-cycle update-to-read bypass
- an in-stage hit compare
- invalid-first pseudo-LRU victim selection

It sits between the L2 arbiter and the L2 directory/update stage, which drives all update ports.

---
 rtl/l2_tag_stage_nway.sv | 223 ++++++++++++++++++++++
 tb/tb_l2_tag_stage_nway.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tag_stage_nway.sv
// Purpose: L2 tag-check stage. Registers the arbiter request and presents the addressed set's tag, valid, dirty and PLRU view, plus hit and victim.
// Latency: 1 cycle from accept to tag_valid. The array view shows every update committed in the previous cycle.
// Backpressure: tag_ready = !dn_stall once the init sweep is done. A stalled request holds, but its array view keeps tracking updates.
module l2_tag_stage_nway #(
    parameter int NUM_WAYS      = 4,
    parameter int NUM_SETS      = 256,
    parameter int TAG_WIDTH     = 18,
    parameter int ADDR_WIDTH    = 26,
    parameter int PAYLOAD_WIDTH = 600,
    localparam int WAY_IDX_W    = $clog2(NUM_WAYS),
    localparam int SET_W        = $clog2(NUM_SETS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            arb_valid,
    output logic                            tag_ready,
    input  logic [ADDR_WIDTH-1:0]           arb_addr,
    input  logic                            arb_is_fill,
    input  logic [PAYLOAD_WIDTH-1:0]        arb_payload,
    input  logic                            dn_stall,
    output logic                            tag_valid,
    output logic [ADDR_WIDTH-1:0]           tag_addr,
    output logic                            tag_is_fill,
    output logic [PAYLOAD_WIDTH-1:0]        tag_payload,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]   tag_way_tag,
    output logic [NUM_WAYS-1:0]             tag_way_valid,
    output logic [NUM_WAYS-1:0]             tag_way_dirty,
    output logic                            tag_hit,
    output logic [WAY_IDX_W-1:0]            tag_hit_way,
    output logic [WAY_IDX_W-1:0]            tag_victim_way,
    input  logic                            upd_tag_en,
    input  logic [SET_W-1:0]                upd_tag_set,
    input  logic [WAY_IDX_W-1:0]            upd_tag_way,
    input  logic [TAG_WIDTH-1:0]            upd_tag_tag,
    input  logic                            upd_tag_valid,
    input  logic                            upd_dirty_en,
    input  logic [SET_W-1:0]                upd_dirty_set,
    input  logic [WAY_IDX_W-1:0]            upd_dirty_way,
    input  logic                            upd_dirty_value,
    input  logic                            lru_touch_en,
    input  logic [SET_W-1:0]                lru_touch_set,
    input  logic [WAY_IDX_W-1:0]            lru_touch_way
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                 state_q, state_d;
    logic [SET_W-1:0]       init_cnt_q, init_cnt_d;

    logic                       tag_valid_q, tag_valid_d;
    logic [ADDR_WIDTH-1:0]      tag_addr_q, tag_addr_d;
    logic                       tag_is_fill_q, tag_is_fill_d;
    logic [PAYLOAD_WIDTH-1:0]   tag_payload_q, tag_payload_d;

    // Per-set storage. Tags survive reset. Valid, dirty and PLRU are cleared by the init sweep.
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tag_mem_q   [NUM_SETS];
    logic [NUM_WAYS-1:0]                vld_mem_q   [NUM_SETS];
    logic [NUM_WAYS-1:0]                dirty_mem_q [NUM_SETS];
    logic [NUM_WAYS-2:0]                plru_mem_q  [NUM_SETS];

    logic [SET_W-1:0]                   rd_set;
    logic [TAG_WIDTH-1:0]               rd_tag;
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] rd_tags;
    logic [NUM_WAYS-1:0]                rd_vld;
    logic [NUM_WAYS-1:0]                rd_dirty;
    logic [NUM_WAYS-2:0]                rd_plru;
    logic                               hit_c;
    logic [WAY_IDX_W-1:0]               hit_way_c;
    logic [WAY_IDX_W-1:0]               victim_c;

    // Tree nodes are heap-indexed from 1. A node bit of 1 means the LRU side is the upper half.
    function automatic logic [WAY_IDX_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] nodes);
        logic [NUM_WAYS-1:0]  tree;
        logic [WAY_IDX_W-1:0] n;
        logic [WAY_IDX_W-1:0] w;
        logic                 b;
        tree = {nodes, 1'b0};
        n    = WAY_IDX_W'(1);
        w    = '0;
        for (int l = 0; l < WAY_IDX_W; l++) begin
            b = tree[n];
            w = (w << 1) | WAY_IDX_W'(b);
            n = (n << 1) | WAY_IDX_W'(b);
        end
        return w;
    endfunction

    // Every node on the touched way's path is pointed at the opposite child.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] nodes,
                                                       input logic [WAY_IDX_W-1:0] way);
        logic [NUM_WAYS-1:0]  tree;
        logic [WAY_IDX_W-1:0] n;
        logic [WAY_IDX_W-1:0] w;
        logic                 b;
        tree = {nodes, 1'b0};
        n    = WAY_IDX_W'(1);
        w    = way;
        for (int l = 0; l < WAY_IDX_W; l++) begin
            b       = w[WAY_IDX_W-1];
            w       = w << 1;
            tree[n] = ~b;
            n       = (n << 1) | WAY_IDX_W'(b);
        end
        return tree[NUM_WAYS-1:1];
    endfunction

    assign tag_ready = (state_q == ST_RUN) && !dn_stall;

    // Init sweep walks every set once, then the stage runs.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + SET_W'(1);
                if (init_cnt_q == SET_W'(NUM_SETS-1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM and sweep counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Request pipe. It loads on accept, drains when idle and holds under stall.
    always_comb begin
        tag_valid_d   = tag_valid_q;
        tag_addr_d    = tag_addr_q;
        tag_is_fill_d = tag_is_fill_q;
        tag_payload_d = tag_payload_q;
        if (tag_ready) begin
            tag_valid_d = arb_valid;
            if (arb_valid) begin
                tag_addr_d    = arb_addr;
                tag_is_fill_d = arb_is_fill;
                tag_payload_d = arb_payload;
            end
        end
    end

    // Request pipe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_q   <= 1'b0;
            tag_addr_q    <= '0;
            tag_is_fill_q <= 1'b0;
            tag_payload_q <= '0;
        end else begin
            tag_valid_q   <= tag_valid_d;
            tag_addr_q    <= tag_addr_d;
            tag_is_fill_q <= tag_is_fill_d;
            tag_payload_q <= tag_payload_d;
        end
    end

    // Array writes. The sweep clears state bits, and update/touch ports are ignored until it finishes.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            vld_mem_q[init_cnt_q]   <= '0;
            dirty_mem_q[init_cnt_q] <= '0;
            plru_mem_q[init_cnt_q]  <= '0;
        end else begin
            if (upd_tag_en) begin
                tag_mem_q[upd_tag_set][upd_tag_way] <= upd_tag_tag;
                vld_mem_q[upd_tag_set][upd_tag_way] <= upd_tag_valid;
            end
            if (upd_dirty_en) begin
                dirty_mem_q[upd_dirty_set][upd_dirty_way] <= upd_dirty_value;
            end
            if (lru_touch_en) begin
                plru_mem_q[lru_touch_set] <= plru_touch(plru_mem_q[lru_touch_set], lru_touch_way);
            end
        end
    end

    // The array is read with the registered set. Writes from the previous cycle are therefore visible, which gives the bypass for free.
    assign rd_set   = tag_addr_q[SET_W-1:0];
    assign rd_tag   = tag_addr_q[ADDR_WIDTH-1:SET_W];
    assign rd_tags  = tag_mem_q[rd_set];
    assign rd_vld   = vld_mem_q[rd_set];
    assign rd_dirty = dirty_mem_q[rd_set];
    assign rd_plru  = plru_mem_q[rd_set];

    // Lowest-index hit. The victim is the lowest invalid way, falling back to tree PLRU.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        for (int i = NUM_WAYS-1; i >= 0; i--) begin
            if (rd_vld[i] && (rd_tags[i] == rd_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_IDX_W'(i);
            end
        end
        if (&rd_vld) begin
            victim_c = plru_victim(rd_plru);
        end else begin
            for (int i = NUM_WAYS-1; i >= 0; i--) begin
                if (!rd_vld[i]) victim_c = WAY_IDX_W'(i);
            end
        end
    end

    assign tag_valid      = tag_valid_q;
    assign tag_addr       = tag_addr_q;
    assign tag_is_fill    = tag_is_fill_q;
    assign tag_payload    = tag_payload_q;
    assign tag_way_tag    = tag_valid_q ? rd_tags  : '0;
    assign tag_way_valid  = tag_valid_q ? rd_vld   : '0;
    assign tag_way_dirty  = tag_valid_q ? rd_dirty : '0;
    assign tag_hit        = tag_valid_q & hit_c;
    assign tag_hit_way    = tag_valid_q ? hit_way_c : '0;
    assign tag_victim_way = tag_valid_q ? victim_c  : '0;

endmodule

// File: tb/tb_l2_tag_stage_nway.sv
// Directed bench for l2_tag_stage_nway: init sweep, hit, bypass, stall snoop, PLRU victim, reset mid-stall.
// Inputs change 1 ns after the rising edge. Outputs are sampled before the next edge.
// Bounded waits fail rather than hang. A watchdog ends the run if anything stalls.
module tb_l2_tag_stage_nway;
    localparam int NW  = 4;
    localparam int NS  = 256;
    localparam int TW  = 18;
    localparam int AW  = 26;
    localparam int PW  = 600;
    localparam int WIW = 2;
    localparam int SW  = 8;

    logic            clk;
    logic            reset_n;
    logic            arb_valid;
    logic            tag_ready;
    logic [AW-1:0]   arb_addr;
    logic            arb_is_fill;
    logic [PW-1:0]   arb_payload;
    logic            dn_stall;
    logic            tag_valid;
    logic [AW-1:0]   tag_addr;
    logic            tag_is_fill;
    logic [PW-1:0]   tag_payload;
    logic [NW*TW-1:0] tag_way_tag;
    logic [NW-1:0]   tag_way_valid;
    logic [NW-1:0]   tag_way_dirty;
    logic            tag_hit;
    logic [WIW-1:0]  tag_hit_way;
    logic [WIW-1:0]  tag_victim_way;
    logic            upd_tag_en;
    logic [SW-1:0]   upd_tag_set;
    logic [WIW-1:0]  upd_tag_way;
    logic [TW-1:0]   upd_tag_tag;
    logic            upd_tag_valid;
    logic            upd_dirty_en;
    logic [SW-1:0]   upd_dirty_set;
    logic [WIW-1:0]  upd_dirty_way;
    logic            upd_dirty_value;
    logic            lru_touch_en;
    logic [SW-1:0]   lru_touch_set;
    logic [WIW-1:0]  lru_touch_way;

    int vecs = 0;
    int errs = 0;

    l2_tag_stage_nway #(
        .NUM_WAYS(NW), .NUM_SETS(NS), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .arb_valid(arb_valid), .tag_ready(tag_ready), .arb_addr(arb_addr),
        .arb_is_fill(arb_is_fill), .arb_payload(arb_payload), .dn_stall(dn_stall),
        .tag_valid(tag_valid), .tag_addr(tag_addr), .tag_is_fill(tag_is_fill),
        .tag_payload(tag_payload), .tag_way_tag(tag_way_tag), .tag_way_valid(tag_way_valid),
        .tag_way_dirty(tag_way_dirty), .tag_hit(tag_hit), .tag_hit_way(tag_hit_way),
        .tag_victim_way(tag_victim_way),
        .upd_tag_en(upd_tag_en), .upd_tag_set(upd_tag_set), .upd_tag_way(upd_tag_way),
        .upd_tag_tag(upd_tag_tag), .upd_tag_valid(upd_tag_valid),
        .upd_dirty_en(upd_dirty_en), .upd_dirty_set(upd_dirty_set),
        .upd_dirty_way(upd_dirty_way), .upd_dirty_value(upd_dirty_value),
        .lru_touch_en(lru_touch_en), .lru_touch_set(lru_touch_set), .lru_touch_way(lru_touch_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p1;
        logic [PW-1:0] p2;
        logic [AW-1:0] a;
        int n;
        p1 = {20{30'h2AB3_C1D5}};
        p2 = {20{30'h1357_9BDF}};

        reset_n = 1'b0; arb_valid = 1'b0; arb_addr = '0; arb_is_fill = 1'b0; arb_payload = '0;
        dn_stall = 1'b0; upd_tag_en = 1'b0; upd_tag_set = '0; upd_tag_way = '0; upd_tag_tag = '0;
        upd_tag_valid = 1'b0; upd_dirty_en = 1'b0; upd_dirty_set = '0; upd_dirty_way = '0;
        upd_dirty_value = 1'b0; lru_touch_en = 1'b0; lru_touch_set = '0; lru_touch_way = '0;

        // Reset state
        #3;
        check("rst_ready", tag_ready, 0);
        check("rst_valid", tag_valid, 0);
        check("rst_addr", tag_addr, 0);
        check("rst_way_valid", tag_way_valid, 0);
        check("rst_victim", tag_victim_way, 0);
        check("rst_hit", tag_hit, 0);
        #19 reset_n = 1'b1;

        // Init sweep length: ready stays low for exactly NUM_SETS edges
        n = 0;
        while (!tag_ready && n < 400) begin cyc(); n++; end
        check("init_ready_low_cycles", n, NS);

        // First read of every set: everything invalid, victim way 0
        for (int s = 0; s < NS; s++) begin
            a = {TW'(s*3+1), SW'(s)};
            arb_valid = 1'b1; arb_addr = a;
            cyc();
            check("sweep_valid", tag_valid, 1);
            check("sweep_addr", tag_addr, a);
            check("sweep_way_valid", tag_way_valid, 0);
            check("sweep_way_dirty", tag_way_dirty, 0);
            check("sweep_victim", tag_victim_way, 0);
        end
        arb_valid = 1'b0;

        // Write set 5 way 2, then look it up
        upd_tag_en = 1'b1; upd_tag_set = 8'd5; upd_tag_way = 2'd2; upd_tag_tag = 18'h1ABCD; upd_tag_valid = 1'b1;
        cyc();
        upd_tag_en = 1'b0;
        arb_valid = 1'b1; arb_addr = {18'h1ABCD, 8'd5}; arb_payload = p1; arb_is_fill = 1'b0;
        cyc();
        arb_valid = 1'b0;
        check("hit5_hit", tag_hit, 1);
        check("hit5_way", tag_hit_way, 2);
        check("hit5_way_valid", tag_way_valid, 4'b0100);
        check("hit5_tag2", tag_way_tag[2*TW +: TW], 18'h1ABCD);
        check("hit5_victim", tag_victim_way, 0);
        check("hit5_payload", tag_payload === p1, 1);

        // Bypass: update set 7 in the same cycle the request is accepted
        arb_valid = 1'b1; arb_addr = {18'h00777, 8'd7};
        upd_tag_en = 1'b1; upd_tag_set = 8'd7; upd_tag_way = 2'd1; upd_tag_tag = 18'h25555; upd_tag_valid = 1'b1;
        cyc();
        check("byp_way_valid", tag_way_valid, 4'b0010);
        check("byp_tag1", tag_way_tag[1*TW +: TW], 18'h25555);
        check("byp_hit", tag_hit, 0);
        check("byp_victim", tag_victim_way, 0);
        upd_tag_way = 2'd3; upd_tag_tag = 18'h00777;
        cyc();
        upd_tag_en = 1'b0; arb_valid = 1'b0;
        check("byp_hit2", tag_hit, 1);
        check("byp_hit2_way", tag_hit_way, 3);
        check("byp_way_valid2", tag_way_valid, 4'b1010);

        // Stall holding set 9 while its dirty bit is written
        arb_valid = 1'b1; arb_addr = {18'h00909, 8'd9}; arb_is_fill = 1'b1; arb_payload = p2;
        cyc();
        check("st_valid", tag_valid, 1);
        check("st_addr", tag_addr, {18'h00909, 8'd9});
        dn_stall = 1'b1; arb_addr = {18'h3FFFF, 8'd10}; arb_payload = p1; arb_is_fill = 1'b0;
        upd_dirty_en = 1'b1; upd_dirty_set = 8'd9; upd_dirty_way = 2'd3; upd_dirty_value = 1'b1;
        #1;
        check("st_ready0", tag_ready, 0);
        check("st_dirty_before", tag_way_dirty, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            upd_dirty_en = 1'b0;
            check("st_ready", tag_ready, 0);
            check("st_hold_valid", tag_valid, 1);
            check("st_hold_addr", tag_addr, {18'h00909, 8'd9});
            check("st_hold_fill", tag_is_fill, 1);
            check("st_hold_payload", tag_payload === p2, 1);
            check("st_dirty", tag_way_dirty, 4'b1000);
        end
        dn_stall = 1'b0; arb_valid = 1'b0;
        cyc();
        check("st_drain", tag_valid, 0);

        // PLRU victim on set 3
        for (int w = 0; w < NW; w++) begin
            upd_tag_en = 1'b1; upd_tag_set = 8'd3; upd_tag_way = WIW'(w);
            upd_tag_tag = TW'(18'h300 + w); upd_tag_valid = 1'b1;
            cyc();
        end
        upd_tag_en = 1'b0;
        for (int w = 0; w < NW; w++) begin
            lru_touch_en = 1'b1; lru_touch_set = 8'd3; lru_touch_way = WIW'(w);
            cyc();
        end
        lru_touch_en = 1'b0;
        arb_valid = 1'b1; arb_addr = {18'h00303, 8'd3};
        cyc();
        arb_valid = 1'b0;
        check("lru_way_valid", tag_way_valid, 4'b1111);
        check("lru_hit_way", tag_hit_way, 3);
        check("lru_victim_0123", tag_victim_way, 0);
        dn_stall = 1'b1;
        lru_touch_en = 1'b1; lru_touch_set = 8'd3; lru_touch_way = 2'd0;
        cyc();
        lru_touch_en = 1'b0;
        check("lru_victim_touch0", tag_victim_way, 2);
        upd_tag_en = 1'b1; upd_tag_set = 8'd3; upd_tag_way = 2'd1; upd_tag_tag = 18'h00301; upd_tag_valid = 1'b0;
        cyc();
        upd_tag_en = 1'b0;
        check("lru_victim_inv1", tag_victim_way, 1);
        check("lru_way_valid_inv1", tag_way_valid, 4'b1101);
        check("lru_hit_inv1", tag_hit, 1);

        // Reset pulse mid-stall
        check("rst2_pre_valid", tag_valid, 1);
        reset_n = 1'b0;
        #1;
        check("rst2_valid", tag_valid, 0);
        check("rst2_addr", tag_addr, 0);
        check("rst2_payload", tag_payload === '0, 1);
        check("rst2_ready", tag_ready, 0);
        check("rst2_way_valid", tag_way_valid, 0);
        check("rst2_victim", tag_victim_way, 0);
        #2;
        reset_n = 1'b1; dn_stall = 1'b0;
        n = 0;
        while (!tag_ready && n < 400) begin cyc(); n++; end
        check("init2_ready_low_cycles", n, NS);
        arb_valid = 1'b1; arb_addr = {18'h00909, 8'd9};
        cyc();
        check("init2_set9_dirty", tag_way_dirty, 0);
        check("init2_set9_valid", tag_way_valid, 0);
        arb_addr = {18'h1ABCD, 8'd5};
        cyc();
        arb_valid = 1'b0;
        check("init2_set5_valid", tag_way_valid, 0);
        check("init2_set5_hit", tag_hit, 0);
        check("init2_set5_tag_kept", tag_way_tag[2*TW +: TW], 18'h1ABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
